// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and small helpers used by the key schedule
// and the cipher datapath.
package aes_pkg;

   localparam int AES_NR = 10;
   localparam int AES_NK = 4;

   typedef logic [31:0]  aes_word_t;
   typedef logic [127:0] aes_block_t;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      DONE
   } ke_state_t;

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Round constant for round i; rounds outside 1..10 contribute nothing.
   function automatic logic [7:0] rcon_of(input logic [3:0] i);
      if (i >= 4'd1 && i <= 4'd10)
         return RCON[i];
      else
         return 8'h00;
   endfunction

   function automatic aes_word_t rot_word(input aes_word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: purely combinational 8-bit substitution lookup.
module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry
// round-key store, read back by index through a registered port.
module aes_key_expander
   import aes_pkg::*;
#(
   parameter int NR    = AES_NR,
   parameter int KEY_W = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic [KEY_W-1:0] key,
   output logic             busy,
   output logic             keys_valid,
   input  logic [3:0]       rk_rd_idx,
   output logic [KEY_W-1:0] rk_rd_data
);

   ke_state_t        state_reg;
   logic [3:0]       round_reg;
   aes_block_t       w_reg;
   logic             key_ready_reg;
   logic             busy_reg;
   logic             keys_valid_reg;
   logic [KEY_W-1:0] rd_data_reg;

   aes_block_t       rk_mem [0:NR];

   logic             accept;
   aes_word_t        rot_w;
   aes_word_t        sub_w;
   aes_word_t        t_word;
   aes_word_t        w_words [0:3];
   aes_word_t        w_next_words [0:3];
   aes_block_t       w_next;

   logic             wr_en;
   logic [3:0]       wr_idx;
   aes_block_t       wr_data;

   assign accept = key_valid && key_ready_reg;

   // SubWord(RotWord(last word)) with the round constant folded into the top byte.
   assign rot_w = rot_word(w_reg[31:0]);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_subword
         aes_sbox u_sbox (
            .din  (rot_w[gi*8 +: 8]),
            .dout (sub_w[gi*8 +: 8])
         );
      end
   endgenerate

   assign t_word = sub_w ^ {rcon_of(round_reg), 24'h000000};

   // Words are chained: each new word folds in the freshly computed one before it.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_words
         assign w_words[gi] = w_reg[127 - gi*32 -: 32];
         if (gi == 0) begin : g_first
            assign w_next_words[gi] = w_words[gi] ^ t_word;
         end else begin : g_chain
            assign w_next_words[gi] = w_words[gi] ^ w_next_words[gi-1];
         end
         assign w_next[127 - gi*32 -: 32] = w_next_words[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         round_reg      <= 4'd0;
         w_reg          <= '0;
         key_ready_reg  <= 1'b1;
         busy_reg       <= 1'b0;
         keys_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (accept) begin
                  w_reg          <= key;
                  round_reg      <= 4'd1;
                  state_reg      <= EXPAND;
                  key_ready_reg  <= 1'b0;
                  busy_reg       <= 1'b1;
                  keys_valid_reg <= 1'b0;
               end
            end
            EXPAND: begin
               w_reg     <= w_next;
               round_reg <= round_reg + 4'd1;
               if (round_reg == 4'(NR)) begin
                  state_reg      <= DONE;
                  key_ready_reg  <= 1'b1;
                  busy_reg       <= 1'b0;
                  keys_valid_reg <= 1'b1;
               end
            end
            default: begin
               state_reg      <= IDLE;
               key_ready_reg  <= 1'b1;
               busy_reg       <= 1'b0;
               keys_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   // Single write port: the cipher key lands in slot 0, expanded rounds follow.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = 4'd0;
      wr_data = key;
      if (!rst) begin
         if (accept) begin
            wr_en = 1'b1;
         end else if (state_reg == EXPAND) begin
            wr_en   = 1'b1;
            wr_idx  = round_reg;
            wr_data = w_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         rk_mem[wr_idx] <= wr_data;
   end

   // A re-key accept drops keys_valid, so the read in that same cycle returns zero.
   always_ff @(posedge clk) begin
      if (rst)
         rd_data_reg <= '0;
      else if (keys_valid_reg && !accept && rk_rd_idx <= 4'(NR))
         rd_data_reg <= rk_mem[rk_rd_idx];
      else
         rd_data_reg <= '0;
   end

   assign key_ready  = key_ready_reg;
   assign busy       = busy_reg;
   assign keys_valid = keys_valid_reg;
   assign rk_rd_data = rd_data_reg;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: FIPS-197 vectors, control corner
// cases and random keys against a GF(2^8)-derived key-schedule model.
module tb_aes_key_expander;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key;
   logic         busy;
   logic         keys_valid;
   logic [3:0]   rk_rd_idx;
   logic [127:0] rk_rd_data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]   sb_ref [256];
   logic [127:0] exp_rk [11];

   localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY0 = 128'h0;

   aes_key_expander dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key        (key),
      .busy       (busy),
      .keys_valid (keys_valid),
      .rk_rd_idx  (rk_rd_idx),
      .rk_rd_data (rk_rd_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = xtime(a);
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse then the affine map.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] xb  = 8'(x);
         for (int y = 1; y < 256; y++)
            if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
         sb_ref[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   task automatic model_expand(input logic [127:0] k);
      logic [31:0] wd [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) wd[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = wd[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]};
            t ^= {rc, 24'h0};
            rc = xtime(rc);
         end
         wd[i] = wd[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         exp_rk[r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
   endtask

   // ---------------- stimulus helpers (entered and left just after a negedge) ----------------
   task automatic accept_key(input logic [127:0] k);
      int n = 0;
      while (!key_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      key       = k;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      key       = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_valid(input string tag, input int start);
      int n = start;
      while (!keys_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, " latency"}, 128'(n), 128'd10);
   endtask

   task automatic read_range(input string tag, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         rk_rd_idx = 4'(i);
         @(negedge clk);
         check_val($sformatf("%s rk[%0d]", tag, i), rk_rd_data, (i <= 10) ? exp_rk[i] : 128'h0);
      end
   endtask

   task automatic read_one(input string tag, input int idx, input logic [127:0] exp);
      rk_rd_idx = 4'(idx);
      @(negedge clk);
      check_val(tag, rk_rd_data, exp);
   endtask

   initial begin
      rst       = 1'b1;
      key_valid = 1'b0;
      key       = '0;
      rk_rd_idx = 4'd0;
      build_sbox();
      repeat (2) @(negedge clk);
      check_val("reset key_ready", 128'(key_ready), 128'd1);
      check_val("reset busy", 128'(busy), 128'd0);
      check_val("reset keys_valid", 128'(keys_valid), 128'd0);
      check_val("reset rk_rd_data", rk_rd_data, 128'h0);
      rst = 1'b0;
      @(negedge clk);
      read_one("pre-key read idx0", 0, 128'h0);

      // FIPS-197 Appendix A key
      model_expand(KEY1);
      accept_key(KEY1);
      check_val("t1 busy after accept", 128'(busy), 128'd1);
      check_val("t1 key_ready after accept", 128'(key_ready), 128'd0);
      rk_rd_idx = 4'd0;
      @(negedge clk);
      check_val("t1 read during expand", rk_rd_data, 128'h0);
      wait_valid("t1", 1);
      check_val("t1 done key_ready", 128'(key_ready), 128'd1);
      check_val("t1 done busy", 128'(busy), 128'd0);
      read_one("t1 fips rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
      read_one("t1 fips rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      read_range("t1", 0, 15);

      // Key offered during EXPAND must be ignored
      accept_key(KEY1);
      @(negedge clk);
      key       = KEY0;
      key_valid = 1'b1;
      @(negedge clk);
      check_val("t3 key_ready while pulsed", 128'(key_ready), 128'd0);
      @(negedge clk);
      key_valid = 1'b0;
      wait_valid("t3", 3);
      read_range("t3", 0, 10);

      // All-zero key
      model_expand(KEY0);
      accept_key(KEY0);
      wait_valid("t2", 0);
      read_one("t2 fips rk0", 0, 128'h0);
      read_one("t2 fips rk1", 1, 128'h62636363626363636263636362636363);
      read_one("t2 fips rk10", 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      read_range("t2", 0, 15);

      // Reset part-way through expansion, then the zero key
      accept_key(KEY1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("t4 keys_valid after rst", 128'(keys_valid), 128'd0);
      check_val("t4 key_ready after rst", 128'(key_ready), 128'd1);
      check_val("t4 busy after rst", 128'(busy), 128'd0);
      read_one("t4 read after rst", 1, 128'h0);
      accept_key(KEY0);
      wait_valid("t4", 0);
      read_range("t4", 0, 10);

      // Back-to-back re-key from DONE with a read colliding on the accept edge
      model_expand(KEY1);
      accept_key(KEY1);
      wait_valid("t6 first", 0);
      rk_rd_idx = 4'd3;
      @(negedge clk);
      check_val("t6 read before rekey", rk_rd_data, exp_rk[3]);
      model_expand(KEY0);
      accept_key(KEY0);
      check_val("t6 keys_valid at accept", 128'(keys_valid), 128'd0);
      check_val("t6 collided read", rk_rd_data, 128'h0);
      wait_valid("t6 second", 0);
      read_range("t6", 0, 10);

      // Random keys
      for (int r = 0; r < 6; r++) begin
         logic [127:0] rk = {$urandom, $urandom, $urandom, $urandom};
         model_expand(rk);
         accept_key(rk);
         wait_valid($sformatf("rnd%0d", r), 0);
         read_range($sformatf("rnd%0d", r), 0, 11);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
